// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: splits one serial line carrying interleaved
// A/B bits (MSB first, A first) into two parallel W-bit words. A frame is
// 2*W bits long and starts on the bit qualified by sync.
module tdm_demux2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    input  logic         sync,
    output logic         sel,
    output logic         busy,
    output logic [W-1:0] a_data,
    output logic [W-1:0] b_data,
    output logic         a_valid,
    output logic         b_valid,
    output logic         err
);

    localparam int CW = $clog2(2 * W);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    // Bit positions of the final A bit and the final B bit of a frame.
    localparam logic [CW-1:0] LAST_A = CW'(2 * W - 2);
    localparam logic [CW-1:0] LAST_B = CW'(2 * W - 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;

    // Words arriving MSB first: the bit shifted in on this edge becomes the LSB.
    logic [W-1:0]  a_next;
    logic [W-1:0]  b_next;

    assign a_next = {a_sr[W-2:0], din};
    assign b_next = {b_sr[W-2:0], din};

    // The slot of the next expected bit is the low bit of the counter, which
    // sits at 0 whenever the block is idle.
    assign sel  = cnt[0];
    assign busy = (state == RECV);

    // Frame sequencing, slot routing, word completion and abort detection.
    always_ff @(posedge clk) begin
        // NOTE: every register here is written with <= so all of them see
        // the pre-edge values of each other, exactly like the flops do.
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            a_data  <= '0;
            b_data  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Pulses default low so they last one cycle even while en is low.
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            err     <= 1'b0;

            if (en) begin
                if (sync) begin
                    // A sync while receiving abandons the partial words; in
                    // either state the current bit is the new frame's A MSB.
                    err   <= (state == RECV);
                    state <= RECV;
                    cnt   <= CW'(1);
                    a_sr  <= {{(W-1){1'b0}}, din};
                    b_sr  <= '0;
                end else if (state == RECV) begin
                    if (!cnt[0]) begin
                        a_sr <= a_next;
                    end else begin
                        b_sr <= b_next;
                    end

                    if (cnt == LAST_A) begin
                        a_data  <= a_next;
                        a_valid <= 1'b1;
                    end

                    if (cnt == LAST_B) begin
                        b_data  <= b_next;
                        b_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2. A frame-level model collects accepted
// bits into a queue and de-interleaves it when a word is complete; expected
// words and abort pulses are queued with the cycle they must appear on, and
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_tdm_demux2;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        int           stamp;
    } word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         din = 1'b0;
    logic         sync = 1'b0;
    logic         sel;
    logic         busy;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         a_valid;
    logic         b_valid;
    logic         err;

    tdm_demux2 #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .sync    (sync),
        .sel     (sel),
        .busy    (busy),
        .a_data  (a_data),
        .b_data  (b_data),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard queues.
    word_t a_q[$];
    word_t b_q[$];
    int    err_q[$];

    // Reference model: bits accepted so far in the current frame.
    bit           frame[$];
    bit           in_frame = 1'b0;
    logic [W-1:0] nxt_a = '0, nxt_b = '0, exp_a = '0, exp_b = '0;
    bit           nxt_busy = 1'b0, nxt_sel = 1'b0;
    bit           exp_busy = 1'b0, exp_sel = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pull one slot's word out of the interleaved frame (slot 0 = A, 1 = B).
    function automatic logic [W-1:0] deinterleave(input int slot);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = frame[2*i+slot];
        return w;
    endfunction

    // Apply one cycle of inputs, advance the model, and wait for the edge.
    task automatic step(input bit r, input bit e, input bit s, input bit d);
        int           stamp;
        logic [W-1:0] w;
        rst   = r;
        en    = e;
        sync  = s;
        din   = d;
        stamp = cyc + 1;
        if (r) begin
            frame.delete();
            in_frame = 1'b0;
            nxt_a    = '0;
            nxt_b    = '0;
        end else if (e) begin
            if (s) begin
                if (in_frame) err_q.push_back(stamp);
                frame.delete();
                frame.push_back(d);
                in_frame = 1'b1;
            end else if (in_frame) begin
                frame.push_back(d);
                if (frame.size() == 2*W - 1) begin
                    w = deinterleave(0);
                    a_q.push_back('{data: w, stamp: stamp});
                    nxt_a = w;
                end else if (frame.size() == 2*W) begin
                    w = deinterleave(1);
                    b_q.push_back('{data: w, stamp: stamp});
                    nxt_b = w;
                    frame.delete();
                    in_frame = 1'b0;
                end
            end
        end
        nxt_busy = in_frame;
        nxt_sel  = (frame.size() % 2) == 1;
        @(posedge clk);
        #1;
        exp_a    = nxt_a;
        exp_b    = nxt_b;
        exp_busy = nxt_busy;
        exp_sel  = nxt_sel;
    endtask

    // Send the first nbits of the interleaved frame a7,b7,...,a0,b0, with an
    // optional en-low pause (sync and din toggling) before bit pause_at.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits,
                        input int pause_at, input int pause_len);
        bit bv;
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at)
                for (int p = 0; p < pause_len; p++) step(1'b0, 1'b0, 1'b1, 1'($urandom));
            bv = (i % 2 == 0) ? a[W-1-i/2] : b[W-1-i/2];
            step(1'b0, 1'b1, (i == 0), bv);
        end
    endtask

    // Monitor: level checks every cycle, pulse checks against the queues.
    always @(negedge clk) begin
        word_t e;
        int    s;
        check("busy", 32'(busy), 32'(exp_busy));
        check("sel", 32'(sel), 32'(exp_sel));
        check("a_data hold", 32'(a_data), 32'(exp_a));
        check("b_data hold", 32'(b_data), 32'(exp_b));
        if (a_valid !== 1'b0) begin
            if (a_q.size() == 0) check("unexpected a_valid", 32'(a_valid), 32'd0);
            else begin
                e = a_q.pop_front();
                check("a_data word", 32'(a_data), 32'(e.data));
                check("a_valid cycle", 32'(cyc), 32'(e.stamp));
            end
        end
        if (b_valid !== 1'b0) begin
            if (b_q.size() == 0) check("unexpected b_valid", 32'(b_valid), 32'd0);
            else begin
                e = b_q.pop_front();
                check("b_data word", 32'(b_data), 32'(e.data));
                check("b_valid cycle", 32'(cyc), 32'(e.stamp));
            end
        end
        if (err !== 1'b0) begin
            if (err_q.size() == 0) check("unexpected err", 32'(err), 32'd0);
            else begin
                s = err_q.pop_front();
                check("err cycle", 32'(cyc), 32'(s));
            end
        end
    end

    initial begin
        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // Single frame, then idle.
        send(8'hA5, 8'h3C, 2*W, -1, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back frames with no gap.
        send(8'h01, 8'h80, 2*W, -1, 0);
        send(8'hFF, 8'h00, 2*W, -1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Sync re-asserted at bit 6 aborts the frame and restarts.
        send(8'h11, 8'h22, 6, -1, 0);
        send(8'h5A, 8'hC3, 2*W, -1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Three-cycle en-low pause at cnt=7.
        send(8'h96, 8'h69, 2*W, 7, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset at cnt=9, then a clean frame.
        send(8'h12, 8'h34, 9, -1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send(8'hE7, 8'h18, 2*W, -1, 0);

        // din toggling in IDLE with no sync.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'(i));

        // Clean random frames, some with random pauses.
        for (int i = 0; i < 30; i++)
            send(W'($urandom), W'($urandom), 2*W,
                 ($urandom % 2 == 0) ? int'($urandom_range(1, 2*W-1)) : -1,
                 int'($urandom_range(1, 4)));

        // Unconstrained random traffic.
        for (int i = 0; i < 2000; i++)
            step(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 20) == 0, 1'($urandom));

        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

        check("a words outstanding", 32'(a_q.size()), 32'd0);
        check("b words outstanding", 32'(b_q.size()), 32'd0);
        check("err pulses outstanding", 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
